// File: rtl/flag_pkg.sv
// Shared flag indices, update masks and the ALU-op to mask decode
// used by the status-flag unit.
package flag_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_S = 2;
    localparam int FLAG_O = 3;

    localparam logic [3:0] MASK_ZCSO = 4'b1111;
    localparam logic [3:0] MASK_ZCS  = 4'b0111;
    localparam logic [3:0] MASK_ZS   = 4'b0101;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    function automatic logic [3:0] flag_mask(input logic [4:0] op);
        logic [3:0] m;
        m = MASK_NONE;
        case (op) inside
            5'd0, 5'd1, [5'd3:5'd6]:    m = MASK_ZCSO;
            5'd8, 5'd9:                 m = MASK_ZCS;
            5'd17, 5'd18, [5'd20:5'd30]: m = MASK_ZS;
            default:                    m = MASK_NONE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// Parametrised LIFO for saving/restoring the flag register on
// interrupt and call entry/exit, with misuse strobes.
module flag_stack #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic [DW-1:0]    depth,
    output logic             full,
    output logic             empty,
    output logic             pop_ok,
    output logic             over,
    output logic             under,
    output logic             conflict
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] MAX_D = DW'(DEPTH);

    logic [WIDTH-1:0] mem [0:(1 << AW) - 1];
    logic [DW-1:0]    depth_m1;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;

    assign full     = (depth == MAX_D);
    assign empty    = (depth == '0);
    assign depth_m1 = depth - 1'b1;
    assign wr_ptr   = depth[AW-1:0];
    assign rd_ptr   = depth_m1[AW-1:0];
    assign data_out = mem[rd_ptr];

    assign push_ok  = push & ~pop & ~full;
    assign pop_ok   = pop & ~push & ~empty;
    assign over     = push & ~pop & full;
    assign under    = pop & ~push & empty;
    assign conflict = push & pop;

    // Entries are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            depth <= '0;
        end else if (push_ok) begin
            depth <= depth + 1'b1;
        end else if (pop_ok) begin
            depth <= depth_m1;
        end
    end

endmodule

// File: rtl/flag_status_unit.sv
// Processor condition register with masked ALU update, direct write,
// save/restore stack and sticky misuse error bits.
module flag_status_unit
    import flag_pkg::*;
#(
    parameter int NUM_FLAGS   = 4,
    parameter int OP_W        = 5,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             alu_valid,
    input  logic [OP_W-1:0]                  alu_op,
    input  logic [3:0]                       alu_flags,
    input  logic                             wr_en,
    input  logic [NUM_FLAGS-1:0]             wr_data,
    input  logic                             push,
    input  logic                             pop,
    input  logic                             clear_err,
    output logic [NUM_FLAGS-1:0]             flags,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             full,
    output logic                             empty,
    output logic                             err_over,
    output logic                             err_under,
    output logic                             err_conflict
);

    logic [NUM_FLAGS-1:0] top_data;
    logic [NUM_FLAGS-1:0] next_flags;
    logic [3:0]           mask;
    logic                 op_hi_ok;
    logic                 pop_ok;
    logic                 over;
    logic                 under;
    logic                 conflict;

    flag_stack #(
        .WIDTH (NUM_FLAGS),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .data_in  (flags),
        .data_out (top_data),
        .depth    (depth),
        .full     (full),
        .empty    (empty),
        .pop_ok   (pop_ok),
        .over     (over),
        .under    (under),
        .conflict (conflict)
    );

    // Opcodes wider than the decode table must have zero upper bits.
    generate
        if (OP_W > 5) begin : g_wide_op
            assign op_hi_ok = ~|alu_op[OP_W-1:5];
        end else begin : g_narrow_op
            assign op_hi_ok = 1'b1;
        end
    endgenerate

    assign mask = op_hi_ok ? flag_mask(alu_op[4:0]) : MASK_NONE;

    always_comb begin
        next_flags = flags;
        if (pop_ok) begin
            next_flags = top_data;
        end else if (wr_en) begin
            next_flags = wr_data;
        end else if (alu_valid) begin
            next_flags[3:0] = (flags[3:0] & ~mask) | (alu_flags & mask);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags        <= '0;
            err_over     <= 1'b0;
            err_under    <= 1'b0;
            err_conflict <= 1'b0;
        end else begin
            flags        <= next_flags;
            err_over     <= over | (err_over & ~clear_err);
            err_under    <= under | (err_under & ~clear_err);
            err_conflict <= conflict | (err_conflict & ~clear_err);
        end
    end

endmodule

// File: tb/tb_flag_status_unit.sv
// Directed scoreboard bench for flag_status_unit: expectations are
// queued as each step is driven and compared after the clock edge.
module tb_flag_status_unit;

    typedef struct packed {
        logic [3:0] f;
        logic [2:0] d;
        logic       fu;
        logic       em;
        logic       eo;
        logic       eu;
        logic       ec;
    } exp_t;

    logic       clock;
    logic       reset;
    logic       alu_valid;
    logic [4:0] alu_op;
    logic [3:0] alu_flags;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       push;
    logic       pop;
    logic       clear_err;
    logic [3:0] flags;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err_over;
    logic       err_under;
    logic       err_conflict;

    int   checks;
    int   errors;
    exp_t sb[$];

    flag_status_unit #(
        .NUM_FLAGS   (4),
        .OP_W        (5),
        .STACK_DEPTH (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_op       (alu_op),
        .alu_flags    (alu_flags),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .push         (push),
        .pop          (pop),
        .clear_err    (clear_err),
        .flags        (flags),
        .depth        (depth),
        .full         (full),
        .empty        (empty),
        .err_over     (err_over),
        .err_under    (err_under),
        .err_conflict (err_conflict)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic exp_t mk(input logic [3:0] f, input logic [2:0] d,
                                input logic eo, input logic eu,
                                input logic ec);
        exp_t e;
        e.f  = f;
        e.d  = d;
        e.fu = (d == 3'd4);
        e.em = (d == 3'd0);
        e.eo = eo;
        e.eu = eu;
        e.ec = ec;
        return e;
    endfunction

    task automatic check(input string tag);
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL %s scoreboard empty", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            assert (flags === e.f) else begin
                errors++;
                $error("FAIL %s flags got %b want %b", tag, flags, e.f);
            end
            checks++;
            assert ({depth, full, empty} === {e.d, e.fu, e.em}) else begin
                errors++;
                $error("FAIL %s depth/full/empty got %0d/%b/%b want %0d/%b/%b",
                       tag, depth, full, empty, e.d, e.fu, e.em);
            end
            checks++;
            assert ({err_over, err_under, err_conflict} === {e.eo, e.eu, e.ec})
            else begin
                errors++;
                $error("FAIL %s errs o/u/c got %b%b%b want %b%b%b", tag,
                       err_over, err_under, err_conflict, e.eo, e.eu, e.ec);
            end
        end
    endtask

    task automatic idle();
        alu_valid = 1'b0;
        alu_op    = '0;
        alu_flags = '0;
        wr_en     = 1'b0;
        wr_data   = '0;
        push      = 1'b0;
        pop       = 1'b0;
        clear_err = 1'b0;
    endtask

    task automatic step(input string tag, input logic av,
                        input logic [4:0] op, input logic [3:0] af,
                        input logic we, input logic [3:0] wd,
                        input logic pu, input logic po, input logic ce,
                        input exp_t e);
        alu_valid = av;
        alu_op    = op;
        alu_flags = af;
        wr_en     = we;
        wr_data   = wd;
        push      = pu;
        pop       = po;
        clear_err = ce;
        sb.push_back(e);
        @(posedge clock);
        #1;
        idle();
        check(tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle();
        #12;
        sb.push_back(mk(4'b0000, 3'd0, 0, 0, 0));
        check("reset");
        reset = 1'b0;

        step("op00_all",  1, 5'b00000, 4'b1111, 0, 4'h0, 0, 0, 0,
             mk(4'b1111, 3'd0, 0, 0, 0));
        step("op11_zs",   1, 5'b10001, 4'b0000, 0, 4'h0, 0, 0, 0,
             mk(4'b1010, 3'd0, 0, 0, 0));
        step("op30_zs",   1, 5'b11110, 4'b1111, 0, 4'h0, 0, 0, 0,
             mk(4'b1111, 3'd0, 0, 0, 0));
        step("op31_none", 1, 5'b11111, 4'b0000, 0, 4'h0, 0, 0, 0,
             mk(4'b1111, 3'd0, 0, 0, 0));
        step("wr_over_alu", 1, 5'b00000, 4'b1111, 1, 4'b0000, 0, 0, 0,
             mk(4'b0000, 3'd0, 0, 0, 0));
        step("op08_zcs",  1, 5'b01000, 4'b1111, 0, 4'h0, 0, 0, 0,
             mk(4'b0111, 3'd0, 0, 0, 0));
        step("op02_none", 1, 5'b00010, 4'b0000, 0, 4'h0, 0, 0, 0,
             mk(4'b0111, 3'd0, 0, 0, 0));
        step("wr_0101",   0, 5'b00000, 4'b0000, 1, 4'b0101, 0, 0, 0,
             mk(4'b0101, 3'd0, 0, 0, 0));
        step("push_alu",  1, 5'b00000, 4'b1010, 0, 4'h0, 1, 0, 0,
             mk(4'b1010, 3'd1, 0, 0, 0));
        step("pop_wr",    0, 5'b00000, 4'b0000, 1, 4'b1111, 0, 1, 0,
             mk(4'b0101, 3'd0, 0, 0, 0));

        step("lifo_wr",   0, 5'b0, 4'b0, 1, 4'b0001, 0, 0, 0,
             mk(4'b0001, 3'd0, 0, 0, 0));
        step("push1",     0, 5'b0, 4'b0, 1, 4'b0010, 1, 0, 0,
             mk(4'b0010, 3'd1, 0, 0, 0));
        step("push2",     0, 5'b0, 4'b0, 1, 4'b0011, 1, 0, 0,
             mk(4'b0011, 3'd2, 0, 0, 0));
        step("push3",     0, 5'b0, 4'b0, 1, 4'b0100, 1, 0, 0,
             mk(4'b0100, 3'd3, 0, 0, 0));
        step("push4",     0, 5'b0, 4'b0, 1, 4'b0101, 1, 0, 0,
             mk(4'b0101, 3'd4, 0, 0, 0));
        step("push5_over", 0, 5'b0, 4'b0, 1, 4'b0110, 1, 0, 0,
             mk(4'b0110, 3'd4, 1, 0, 0));
        step("pop1",      0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 0,
             mk(4'b0100, 3'd3, 1, 0, 0));
        step("pop2",      0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 0,
             mk(4'b0011, 3'd2, 1, 0, 0));
        step("pop3",      0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 0,
             mk(4'b0010, 3'd1, 1, 0, 0));
        step("pop4",      0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 0,
             mk(4'b0001, 3'd0, 1, 0, 0));
        step("pop5_under", 0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 0,
             mk(4'b0001, 3'd0, 1, 1, 0));
        step("clear",     0, 5'b0, 4'b0, 0, 4'b0, 0, 0, 1,
             mk(4'b0001, 3'd0, 0, 0, 0));
        step("clear_vs_ev", 0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 1,
             mk(4'b0001, 3'd0, 0, 1, 0));
        step("clear2",    0, 5'b0, 4'b0, 0, 4'b0, 0, 0, 1,
             mk(4'b0001, 3'd0, 0, 0, 0));

        step("cf_push1",  0, 5'b0, 4'b0, 0, 4'b0, 1, 0, 0,
             mk(4'b0001, 3'd1, 0, 0, 0));
        step("cf_push2",  0, 5'b0, 4'b0, 0, 4'b0, 1, 0, 0,
             mk(4'b0001, 3'd2, 0, 0, 0));
        step("conflict",  0, 5'b0, 4'b0, 1, 4'b1100, 1, 1, 0,
             mk(4'b1100, 3'd2, 0, 0, 1));
        step("push_d3",   0, 5'b0, 4'b0, 1, 4'b1111, 1, 0, 0,
             mk(4'b1111, 3'd3, 0, 0, 1));

        #3;
        reset = 1'b1;
        #1;
        sb.push_back(mk(4'b0000, 3'd0, 0, 0, 0));
        check("async_reset");
        #2;
        reset = 1'b0;
        step("pop_after_rst", 0, 5'b0, 4'b0, 0, 4'b0, 0, 1, 0,
             mk(4'b0000, 3'd0, 0, 1, 0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_status_unit.md
# flag_status_unit

Parametrised processor status-flag unit. It holds the NUM_FLAGS-bit condition register (Z, C, S, O plus optional extra flags) and updates flags selectively per ALU operation from a shared decode table. It adds a direct-write path and a STACK_DEPTH-entry save/restore stack for interrupt and call entry/exit. It sits between the ALU flag outputs and the branch/condition logic and replaces the fixed 4-flag register.

## Interface
- NUM_FLAGS, 4, flag register width; must be at least 4; bit 0 Z, bit 1 C, bit 2 S, bit 3 O, bits 4+ user flags
- OP_W, 5, width of ALU operation code
- STACK_DEPTH, 4, number of save/restore entries; must be at least 1
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high
- alu_valid  input  1  alu_op/alu_flags are valid this cycle
- alu_op  input  OP_W  operation code, decoded to an update mask
- alu_flags  input  4  ALU result flags {O,S,C,Z}
- wr_en  input  1  direct load of the whole flag register
- wr_data  input  NUM_FLAGS  direct-load value
- push  input  1  save current flags to stack
- pop  input  1  restore flags from stack top
- clear_err  input  1  clears sticky error bits
- flags  output  NUM_FLAGS  current flag register
- depth  output  $clog2(STACK_DEPTH+1)  occupied stack entries
- full  output  1  depth == STACK_DEPTH
- empty  output  1  depth == 0
- err_over  output  1  sticky: push attempted while full
- err_under  output  1  sticky: pop attempted while empty
- err_conflict  output  1  sticky: push and pop asserted together

## Operation
- Reset values: flags = 0, depth = 0, empty = 1, full = 0, all err_* = 0. Stack contents are don't-care.
- Update mask decode (package function):
  - ops 00000, 00001, 00011..00110: mask ZCSO
  - ops 01000, 01001: mask ZCS
  - ops 10001, 10010, 10100..11110: mask ZS
  - any other op: no update
  - Opcodes wider than 5 bits use the low 5 bits for decode; the upper bits must be 0, otherwise no update.
- The ALU update writes only the masked bits; unmasked bits and bits 4+ hold.
- Per-cycle priority for the next value of flags: valid pop > wr_en > alu_valid update > hold.
- Valid push (not full, no pop): stack[depth] <= current flags (the pre-update value), depth+1. A flag update in the same cycle still applies.
- Valid pop (not empty, no push): flags <= stack[depth-1], depth-1. wr_en and alu update in the same cycle are discarded.
- Push while full: stack unchanged, err_over set; the flag update proceeds normally.
- Pop while empty: flags follow the wr_en/alu path, err_under set.
- Push and pop together: the stack and depth are untouched, err_conflict set, and flags follow the wr_en/alu path.
- clear_err clears all err_* bits. An error event in the same cycle wins, so the bit stays 1.
- Reset asserted mid-operation: all state returns to reset values immediately, with no wait for clock.

## Timing
- Every input is sampled on the rising clock edge. flags, depth, full, empty and err_* change one cycle after the causing input (latency 1). There is no combinational input-to-output path.
- full and empty are decoded from registered depth, so they are consistent with depth in the same cycle.
- Back-to-back push/pop every cycle is supported, giving full throughput.

## Structure
- Package flag_pkg holds:
  - flag index constants FLAG_Z=0, FLAG_C=1, FLAG_S=2, FLAG_O=3
  - mask constants MASK_ZCSO, MASK_ZCS, MASK_ZS, MASK_NONE
  - function flag_mask(op) returning a 4-bit mask
- One sub-module, flag_stack: a parametrised LIFO (NUM_FLAGS wide, STACK_DEPTH deep) with push/pop, full/empty/depth and over/under/conflict strobes. The top module owns the flag register, the priority mux and the sticky error bits.

## Test plan
- Reset, then alu_valid with op 00000 and alu_flags 1111 → flags = 1111 next cycle; then op 10001 with alu_flags 0000 → flags = 1010 (C and O held).
- Op 01000 with alu_flags 1111 from flags 0000 → flags = 0111; op 00010 → no change.
- Push at flags = 0101 while alu_valid op 00000 with 1010 in the same cycle → flags = 1010, depth = 1; then pop → flags = 0101, depth = 0, empty = 1.
- With STACK_DEPTH = 4, push 5 times → depth = 4, full = 1, err_over = 1; pop 5 times → LIFO order returned, err_under = 1; clear_err → both errors 0.
- Push and pop together with depth = 2 → depth stays 2, err_conflict = 1. In the same cycle wr_en = 1 with wr_data 1100 → flags = 1100.
- Assert reset between clock edges with depth 3 and flags 1111 → flags = 0 and depth = 0 immediately. A pop after release → err_under = 1.
